sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserialiser, the successor to the fixed 4-bit D_FF shift chain. It collects WIDTH serial bits, qualified by in_valid, into a word and selects bit order with MSB_FIRST. Each completed word is presented on a registered output with a valid/ready handshake, and a sticky overrun flag reports lost words. It sits between a serial bit source, such as a UART/SPI front end, and a word-wide consumer.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in d_out[WIDTH-1]; 0 = first received bit lands in d_out[0].
CNT_W, $clog2(WIDTH), width of bit_cnt; derived, not overridden.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  d_in is sampled this cycle.
d_in  input  1  serial data bit.
clr  input  1  synchronous abort of the partially assembled frame.
d_out  output  WIDTH  assembled word, held stable while out_valid=1.
out_valid  output  1  d_out holds an unconsumed word.
out_ready  input  1  consumer accepts d_out when out_valid=1.
bit_cnt  output  CNT_W  number of bits collected in the current partial frame.
overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset: when rst=1 at posedge, the following are cleared and all other inputs are ignored that cycle.
  - sreg=0, bit_cnt=0, d_out=0, out_valid=0, overrun=0.
- Shifting (in_valid=1, clr=0):
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], d_in}.
  - MSB_FIRST=0: sreg <= {d_in, sreg[WIDTH-1:1]}.
  - bit_cnt increments by 1.
  - in_valid=0: sreg and bit_cnt hold.
- Frame completion: in_valid=1 while bit_cnt==WIDTH-1.
  - The assembled word is the next_sreg value, which includes the current bit.
  - bit_cnt wraps to 0. sreg is not cleared, because the next frame fully overwrites it.
  - Latency: d_out and out_valid update at the same posedge that samples the last bit, so they are visible in the following cycle.
- Output register and handshake:
  - Transfer occurs on a cycle where out_valid=1 and out_ready=1.
  - After a transfer with no completion that cycle, out_valid <= 0. d_out holds its stale value; it is not cleared.
  - Completion with out_valid=0: d_out <= word, out_valid <= 1.
  - Completion with out_valid=1 and out_ready=1 in the same cycle: d_out <= new word, out_valid stays 1. No loss.
  - Completion with out_valid=1 and out_ready=0: the new word is dropped, d_out is unchanged, and overrun <= 1.
  - out_ready is ignored while out_valid=0.
- overrun: cleared only by rst. clr does not clear it.
- clr=1 (and rst=0):
  - bit_cnt <= 0 and sreg <= 0. Any in_valid bit that cycle is discarded; clr wins.
  - Completion is suppressed even when bit_cnt==WIDTH-1.
  - d_out, out_valid and handshake transfers are unaffected; a pending word can still be accepted that cycle.
- Reset mid-frame or with a pending word: all state is lost. The bench expects the reset values at the next cycle.
- Internal state:
  - Implicit two-phase counter: COLLECT (bit_cnt 0..WIDTH-1).
  - Output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on completion.
  - FULL->EMPTY on transfer without completion.
  - FULL->FULL on completion+transfer, or on completion with out_ready=0 (drop plus overrun).
- d_in is treated as a don't-care when in_valid=0; X on d_in must not propagate into state.

Test Plan:
1. Basic word, WIDTH=8, MSB_FIRST=1: rst for 2 cycles, then shift 1,0,1,1,0,0,1,0 with in_valid=1 and out_ready=0 → d_out=8'hB2 and out_valid=1 from the cycle after the 8th bit; bit_cnt reads 0..7, then 0.
2. Bit order, MSB_FIRST=0: same bit stream → d_out=8'h4D. Raise out_ready for 1 cycle → out_valid=0 the next cycle, d_out still 8'h4D.
3. Gapped input: the same 8 bits with in_valid toggling 1,0,1,0,... → identical d_out=8'hB2; bit_cnt holds during gaps; out_valid rises exactly 1 cycle after the 8th qualified bit.
4. Back-to-back with ready: stream 16 bits 8'hA5 then 8'h3C; out_ready=1 on the completion cycle of the second word → 8'hA5 accepted, d_out becomes 8'h3C with out_valid continuously 1; overrun stays 0.
5. Overrun: out_ready=0; send 8'h11 then 8'h22 → d_out stays 8'h11, overrun=1 from the cycle after the 16th bit; overrun persists after clr and after an accept; cleared only by rst.
6. Abort and reset: send 5 bits, assert clr together with in_valid=1 → bit_cnt=0 and no output; then send 8'hF0 → d_out=8'hF0. With out_valid=1 and 3 bits pending, assert rst → d_out=0, out_valid=0, bit_cnt=0, overrun=0.

Source files
------------

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser
//  Description : Parametrised serial-in/parallel-out deserialiser. Collects
//                WIDTH qualified serial bits into a word (bit order chosen by
//                MSB_FIRST) and hands each finished word to a consumer via a
//                registered valid/ready output. Words that complete while the
//                previous one is still unconsumed are dropped and flagged by
//                a sticky overrun bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             d_in,
    input  logic             clr,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    // Index of the final bit of a frame
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    // Output-side state encoding
    localparam logic [0:0] c_S_EMPTY = 1'b0;
    localparam logic [0:0] c_S_FULL  = 1'b1;

    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_d_out;
    logic             r_overrun;
    logic [0:0]       r_state;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic             w_shift;
    logic             w_complete;
    logic             w_load_word;
    logic             w_drop;
    logic             w_out_valid;

    // An abort always wins over an incoming bit; a bit only counts when qualified
    assign w_shift    = in_valid & ~clr;
    assign w_complete = w_shift & (r_bit_cnt == c_LAST_BIT);

    // Shift direction is fixed at elaboration time
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], d_in};
        end else begin : g_lsb_first
            assign w_sreg_shifted = {d_in, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    // Shift register and bit counter; sreg is not cleared on completion
    // because the next frame overwrites every bit anyway
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (clr) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_sreg <= w_sreg_shifted;
            if (r_bit_cnt == c_LAST_BIT) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // Output FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output FSM next state: a completion always leaves a word pending,
    // otherwise a transfer empties the slot
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = c_S_FULL;
                end
            end
            c_S_FULL: begin
                if (!w_complete && out_ready) begin
                    w_state_nxt = c_S_EMPTY;
                end
            end
            default: w_state_nxt = c_S_EMPTY;
        endcase
    end

    // Output FSM decode: load when the slot is free or being freed, drop otherwise
    always_comb begin
        w_out_valid = 1'b0;
        w_load_word = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            c_S_EMPTY: begin
                w_load_word = w_complete;
            end
            c_S_FULL: begin
                w_out_valid = 1'b1;
                w_load_word = w_complete & out_ready;
                w_drop      = w_complete & ~out_ready;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Output word register; holds its stale value after a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= '0;
        end else if (w_load_word) begin
            r_d_out <= w_sreg_shifted;
        end
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign d_out     = r_d_out;
    assign out_valid = w_out_valid;
    assign bit_cnt   = r_bit_cnt;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deser
//  Description : Scoreboard bench for sipo_deser. Two instances (MSB-first and
//                LSB-first) share one stimulus stream; expected words are
//                queued per instance and popped by a monitor whenever a new
//                word appears on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             d_in;
    logic             clr;
    logic             out_ready;

    logic [WIDTH-1:0] d_out_m, d_out_l;
    logic             ov_m, ov_l;
    logic [CNT_W-1:0] cnt_m, cnt_l;
    logic             ovr_m, ovr_l;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q_m[$];
    logic [WIDTH-1:0] q_l[$];

    logic pv_m = 1'b0, pr_m = 1'b0;
    logic pv_l = 1'b0, pr_l = 1'b0;

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .clr(clr),
        .d_out(d_out_m), .out_valid(ov_m), .out_ready(out_ready),
        .bit_cnt(cnt_m), .overrun(ovr_m)
    );

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .clr(clr),
        .d_out(d_out_l), .out_valid(ov_l), .out_ready(out_ready),
        .bit_cnt(cnt_l), .overrun(ovr_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is on the output when valid rises or stays high
    // right after a transfer
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (ov_m && (!pv_m || pr_m)) begin
            if (q_m.size() == 0) begin
                checks++; failures++;
                $display("FAIL word_msb: got unexpected 0x%0h expected no word", d_out_m);
            end else begin
                e = q_m.pop_front();
                chk("word_msb", 32'(d_out_m), 32'(e));
            end
        end
        if (ov_l && (!pv_l || pr_l)) begin
            if (q_l.size() == 0) begin
                checks++; failures++;
                $display("FAIL word_lsb: got unexpected 0x%0h expected no word", d_out_l);
            end else begin
                e = q_l.pop_front();
                chk("word_lsb", 32'(d_out_l), 32'(e));
            end
        end
        pv_m <= ov_m; pr_m <= out_ready;
        pv_l <= ov_l; pr_l <= out_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        d_in     = b;
        step();
        in_valid = 1'b0;
        d_in     = 1'bx;
    endtask

    // Send a word MSB-first on the wire; wm/wl are the hand-computed words
    // each instance should assemble
    task automatic send_word(input logic [7:0] w, input logic [7:0] wm, input logic [7:0] wl,
                             input bit push, input bit rdy_last, input bit chk_cnt);
        for (int i = 0; i < 8; i++) begin
            if (chk_cnt) chk("bit_cnt_run", 32'(cnt_m), i);
            if (i == 7) begin
                if (push) begin
                    q_m.push_back(wm);
                    q_l.push_back(wl);
                end
                out_ready = rdy_last;
            end
            send_bit(w[7-i]);
        end
        out_ready = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; d_in = 1'b0; clr = 1'b0; out_ready = 1'b0;
        do_reset(2);
        chk("rst_dout", 32'(d_out_m), 0);
        chk("rst_valid", 32'(ov_m), 0);
        chk("rst_cnt", 32'(cnt_m), 0);
        chk("rst_overrun", 32'(ovr_m), 0);

        // Basic word, both bit orders
        send_word(8'hB2, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b1);
        chk("t1_valid", 32'(ov_m), 1);
        chk("t1_dout_m", 32'(d_out_m), 32'hB2);
        chk("t1_dout_l", 32'(d_out_l), 32'h4D);
        chk("t1_cnt_wrap", 32'(cnt_m), 0);

        // Accept: valid drops, data stays
        accept();
        chk("t2_valid", 32'(ov_l), 0);
        chk("t2_dout_l", 32'(d_out_l), 32'h4D);

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'hB2;
            if (i == 7) begin
                chk("t3_valid_before", 32'(ov_m), 0);
                q_m.push_back(8'hB2);
                q_l.push_back(8'h4D);
            end
            send_bit(w[7-i]);
            if (i == 7) chk("t3_valid_after", 32'(ov_m), 1);
            step();
            chk("t3_cnt_hold", 32'(cnt_m), (i + 1) % 8);
        end
        chk("t3_dout_m", 32'(d_out_m), 32'hB2);
        accept();

        // Back-to-back with ready on the second completion
        send_word(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("t4_valid_mid", 32'(ov_m), 1);
        send_word(8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("t4_valid", 32'(ov_m), 1);
        chk("t4_dout_m", 32'(d_out_m), 32'h3C);
        chk("t4_overrun", 32'(ovr_m), 0);
        accept();

        // Overrun
        send_word(8'h11, 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 8'h22, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("t5_overrun", 32'(ovr_m), 1);
        chk("t5_overrun_l", 32'(ovr_l), 1);
        chk("t5_dout_m", 32'(d_out_m), 32'h11);
        chk("t5_dout_l", 32'(d_out_l), 32'h88);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t5_overrun_clr", 32'(ovr_m), 1);
        accept();
        chk("t5_valid_acc", 32'(ov_m), 0);
        chk("t5_overrun_acc", 32'(ovr_m), 1);
        do_reset(1);
        chk("t5_overrun_rst", 32'(ovr_m), 0);

        // Abort after 5 bits, clr wins over in_valid
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        clr = 1'b1; in_valid = 1'b1; d_in = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; d_in = 1'bx;
        chk("t6_cnt_clr", 32'(cnt_m), 0);
        chk("t6_valid_clr", 32'(ov_m), 0);
        // Abort on the last bit suppresses completion
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        clr = 1'b1; in_valid = 1'b1; d_in = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; d_in = 1'bx;
        chk("t6_cnt_clr7", 32'(cnt_m), 0);
        chk("t6_valid_clr7", 32'(ov_m), 0);
        send_word(8'hF0, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1);
        chk("t6_dout_m", 32'(d_out_m), 32'hF0);
        chk("t6_dout_l", 32'(d_out_l), 32'h0F);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t6_cnt3", 32'(cnt_m), 3);
        do_reset(1);
        chk("t6_rst_dout", 32'(d_out_m), 0);
        chk("t6_rst_valid", 32'(ov_m), 0);
        chk("t6_rst_cnt", 32'(cnt_m), 0);
        chk("t6_rst_overrun", 32'(ovr_m), 0);

        repeat (3) step();
        chk("queue_msb_empty", 32'(q_m.size()), 0);
        chk("queue_lsb_empty", 32'(q_l.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
